// File: rtl/cic_pass_sequencer.sv
// cic_pass_sequencer: time-multiplexes the shared CIC unit over all channels, integrator pass per strobe, comb pass per decimation period
module cic_pass_sequencer #(
  parameter int CHANNELS = 8,
  parameter int DEC_WIDTH = 10,
  parameter int CH_W = $clog2(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [DEC_WIDTH-1:0] decimation_ratio,
  input  logic                 pdm_strobe,
  input  logic                 overrun_clr,
  output logic                 int_rd_en,
  output logic                 int_wr_en,
  output logic                 comb_rd_en,
  output logic                 comb_wr_en,
  output logic                 out_we,
  output logic [CH_W-1:0]      channel,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 overrun
);
  typedef enum logic [2:0] {S_IDLE, S_INT_RD, S_INT_WR, S_COMB_RD, S_COMB_WR, S_DONE} state_t;
  state_t state, state_d;
  logic [CH_W-1:0] channel_d;
  logic [DEC_WIDTH-1:0] dec_cnt, dec_cnt_d, ratio_q, ratio_d;
  logic overrun_d, last_ch, period_end;
  assign last_ch = channel == CH_W'(CHANNELS - 1);
  assign period_end = dec_cnt == ratio_q - DEC_WIDTH'(1);
  always_comb begin
    state_d = state;
    channel_d = channel;
    dec_cnt_d = dec_cnt;
    ratio_d = ratio_q;
    overrun_d = enable ? (pdm_strobe && state != S_IDLE) || (overrun && !overrun_clr) : overrun;
    if (!enable) begin
      state_d = S_IDLE;
      channel_d = '0;
      dec_cnt_d = '0;
      ratio_d = DEC_WIDTH'(1);
    end else begin
      case (state)
        S_IDLE: if (pdm_strobe) begin
          state_d = S_INT_RD;
          channel_d = '0;
          if (dec_cnt == '0) ratio_d = (decimation_ratio == '0) ? DEC_WIDTH'(1) : decimation_ratio;
        end
        S_INT_RD: state_d = S_INT_WR;
        S_INT_WR: if (!last_ch) begin
          state_d = S_INT_RD;
          channel_d = channel + 1'b1;
        end else begin
          state_d = period_end ? S_COMB_RD : S_IDLE;
          channel_d = '0;
          dec_cnt_d = period_end ? '0 : dec_cnt + 1'b1;
        end
        S_COMB_RD: state_d = S_COMB_WR;
        S_COMB_WR: if (!last_ch) begin
          state_d = S_COMB_RD;
          channel_d = channel + 1'b1;
        end else begin
          state_d = S_DONE;
          channel_d = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      channel <= '0;
      dec_cnt <= '0;
      ratio_q <= DEC_WIDTH'(1);
      overrun <= 1'b0;
    end else begin
      state <= state_d;
      channel <= channel_d;
      dec_cnt <= dec_cnt_d;
      ratio_q <= ratio_d;
      overrun <= overrun_d;
    end
  end
  assign int_rd_en = state == S_INT_RD;
  assign int_wr_en = state == S_INT_WR;
  assign comb_rd_en = state == S_COMB_RD;
  assign comb_wr_en = state == S_COMB_WR;
  assign out_we = state == S_COMB_WR;
  assign frame_done = state == S_DONE;
  assign busy = state != S_IDLE;
endmodule

// File: tb/tb_cic_pass_sequencer.sv
// tb_cic_pass_sequencer: randomized scoreboard bench; a schedule model pushes expected per-cycle activity, a monitor pops and compares
module tb_cic_pass_sequencer;
  localparam int C = 4;
  localparam int DW = 10;
  localparam int CW = $clog2(C);
  localparam logic [5:0] V_IRD = 6'b100000, V_IWR = 6'b010000, V_CRD = 6'b001000,
                         V_CWR = 6'b000110, V_DONE = 6'b000001;
  logic clk = 0, resetn = 0, enable = 0, pdm_strobe = 0, overrun_clr = 0;
  logic [DW-1:0] decimation_ratio = 3;
  logic int_rd_en, int_wr_en, comb_rd_en, comb_wr_en, out_we, frame_done, busy, overrun;
  logic [CW-1:0] channel;
  typedef struct {int cyc; logic [5:0] v; int ch;} ev_t;
  ev_t q[$];
  int cyc = 0, free_at = 0, m_dec = 0, m_ratio = 1, done_cnt = 0, total = 0, passed = 0;
  logic m_ovr = 0;

  cic_pass_sequencer #(.CHANNELS(C), .DEC_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .decimation_ratio(decimation_ratio),
    .pdm_strobe(pdm_strobe), .overrun_clr(overrun_clr), .int_rd_en(int_rd_en),
    .int_wr_en(int_wr_en), .comb_rd_en(comb_rd_en), .comb_wr_en(comb_wr_en), .out_we(out_we),
    .channel(channel), .frame_done(frame_done), .busy(busy), .overrun(overrun));

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    else passed++;
  endtask

  function automatic void push_ev(int c, logic [5:0] v, int ch);
    ev_t e;
    e.cyc = c;
    e.v = v;
    e.ch = ch;
    q.push_back(e);
  endfunction

  // Reference schedule: an accepted strobe at edge e owns cycles e..free_at-1
  initial forever begin
    bit idle_prev, comb;
    @(posedge clk);
    cyc++;
    if (!resetn || !enable) begin
      q.delete();
      free_at = cyc;
      m_dec = 0;
      m_ratio = 1;
      if (!resetn) m_ovr = 0;
    end else begin
      idle_prev = (cyc - 1) >= free_at;
      if (pdm_strobe && !idle_prev) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
      if (pdm_strobe && idle_prev) begin
        if (m_dec == 0) m_ratio = (decimation_ratio == 0) ? 1 : int'(decimation_ratio);
        comb = (m_dec + 1) % m_ratio == 0;
        m_dec = comb ? 0 : m_dec + 1;
        for (int k = 0; k < C; k++) begin
          push_ev(cyc + 2*k, V_IRD, k);
          push_ev(cyc + 2*k + 1, V_IWR, k);
        end
        if (comb) begin
          for (int k = 0; k < C; k++) begin
            push_ev(cyc + 2*C + 2*k, V_CRD, k);
            push_ev(cyc + 2*C + 2*k + 1, V_CWR, k);
          end
          push_ev(cyc + 4*C, V_DONE, 0);
          free_at = cyc + 4*C + 1;
        end else free_at = cyc + 2*C;
      end
    end
  end

  initial forever begin
    logic [5:0] ev;
    int ech;
    @(negedge clk);
    if (resetn) begin
      ev = 6'b0;
      ech = 0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ev = q[0].v;
        ech = q[0].ch;
        void'(q.pop_front());
      end
      chk("activity", int'({int_rd_en, int_wr_en, comb_rd_en, comb_wr_en, out_we, frame_done}), int'(ev));
      chk("channel", int'(channel), ech);
      chk("busy", int'(busy), int'(cyc < free_at));
      chk("overrun", int'(overrun), int'(m_ovr));
      if (frame_done) done_cnt++;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic strobe(bit clr = 0);
    pdm_strobe = 1;
    overrun_clr = clr;
    tick();
    pdm_strobe = 0;
    overrun_clr = 0;
  endtask

  task automatic restart();
    enable = 0;
    tick();
    enable = 1;
    tick();
  endtask

  task automatic strobes(int n, int gap, int ratio_after_first, int exp_frames, string name);
    int d0 = done_cnt;
    for (int i = 0; i < n; i++) begin
      strobe();
      if (i == 0 && ratio_after_first >= 0) decimation_ratio = DW'(ratio_after_first);
      tick(gap - 1);
    end
    chk(name, done_cnt - d0, exp_frames);
  endtask

  initial begin
    int d0, found;
    tick();
    // Reset held: strobes must not wake the sequencer
    enable = 1;
    pdm_strobe = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outputs", int'({int_rd_en, int_wr_en, comb_rd_en, comb_wr_en, out_we, frame_done, busy, overrun}), 0);
      chk("reset_channel", int'(channel), 0);
    end
    pdm_strobe = 0;
    resetn = 1;
    tick();
    strobes(1, 12, -1, 0, "t1_no_frame");
    restart();
    strobes(3, 20, -1, 1, "t2_three_strobes");
    strobes(6, 20, -1, 2, "t2_six_strobes");
    decimation_ratio = 1;
    restart();
    strobe();
    tick(9);
    strobe();
    chk("t3_overrun_set", int'(overrun), 1);
    tick(12);
    overrun_clr = 1;
    tick();
    overrun_clr = 0;
    chk("t3_overrun_clr", int'(overrun), 0);
    strobe();
    tick(3);
    strobe(1);
    chk("t3_set_wins", int'(overrun), 1);
    tick(20);
    overrun_clr = 1;
    tick();
    overrun_clr = 0;
    decimation_ratio = 4;
    restart();
    strobes(4, 20, 2, 1, "t4_ratio4_then2");
    strobes(2, 20, -1, 1, "t4_ratio2");
    decimation_ratio = 0;
    strobes(3, 20, -1, 3, "t4_ratio0");
    decimation_ratio = 1;
    strobe();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (comb_rd_en && channel == 2) found = 1;
      else tick();
    end
    chk("t5_reach_comb_ch2", found, 1);
    enable = 0;
    tick();
    chk("t5_idle_after_drop", int'({busy, comb_rd_en, comb_wr_en, out_we, frame_done}), 0);
    tick(3);
    enable = 1;
    decimation_ratio = 2;
    tick();
    strobes(1, 20, -1, 0, "t5_first_after_enable");
    strobes(1, 20, -1, 1, "t5_second_after_enable");
    strobe();
    tick(3);
    #1 resetn = 0;
    #1 chk("t6_async_clear", int'({int_rd_en, int_wr_en, comb_rd_en, comb_wr_en, out_we, frame_done, busy}), 0);
    chk("t6_async_channel", int'(channel), 0);
    tick();
    resetn = 1;
    tick();
    strobes(1, 20, -1, 0, "t6_after_reset");
    strobes(1, 20, -1, 1, "t6_second_after_reset");
    // Randomized traffic: gaps straddling pass lengths, ratio changes, clears, enable drops
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) decimation_ratio = DW'($urandom_range(0, 4));
      if ($urandom_range(0, 29) == 0) restart();
      strobe($urandom_range(0, 5) == 0);
      tick($urandom_range(0, 20));
    end
    d0 = 0;
    for (int i = 0; i < 100 && (q.size() > 0 || busy); i++) tick();
    chk("drain_idle", int'(busy), 0);
    chk("drain_queue_empty", q.size(), 0);
    tick(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
